// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline controller slice.
// pipe_state_t is the controller FSM encoding, ctrl_t bundles the per-cycle
// control outputs, and sat_inc is the saturating step used by the
// optional performance counters.
package pipe_ctrl_pkg;

  localparam int MCYC_LEN_W = 3;
  localparam int PERF_CNT_W = 16;
  localparam int RAM_ADDR_W = 12;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    MCYC = 2'd1,
    HALT = 2'd2
  } pipe_state_t;

  typedef struct packed {
    logic stall;
    logic flush;
    logic flush_DE;
    logic halted;
    logic busy;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] value);
    if (value == {PERF_CNT_W{1'b1}}) begin
      return value;
    end
    return value + {{(PERF_CNT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle of pipeline request and control signals between the decode/execute
// datapath (master) and the pipeline controller (slave).
interface pipe_ctrl_if;
  import pipe_ctrl_pkg::*;

  logic                  halt_D;
  logic                  branch_taken_E;
  logic                  mcyc_start_E;
  logic [MCYC_LEN_W-1:0] mcyc_len;
  logic                  ram_wr_E;
  logic                  ram_rd_D;
  logic [RAM_ADDR_W-1:0] K_E;
  logic [RAM_ADDR_W-1:0] K_D;
  logic                  resume;

  logic                  stall;
  logic                  flush;
  logic                  flush_DE;
  logic                  halted;
  logic                  busy;
  logic [PERF_CNT_W-1:0] stall_cnt;
  logic [PERF_CNT_W-1:0] flush_cnt;

  modport master (
    output halt_D, branch_taken_E, mcyc_start_E, mcyc_len,
           ram_wr_E, ram_rd_D, K_E, K_D, resume,
    input  stall, flush, flush_DE, halted, busy, stall_cnt, flush_cnt
  );

  modport slave (
    input  halt_D, branch_taken_E, mcyc_start_E, mcyc_len,
           ram_wr_E, ram_rd_D, K_E, K_D, resume,
    output stall, flush, flush_DE, halted, busy, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/pipe_ctrl_mcyc_counter.sv
// Down-counter tracking the remaining stall cycles of a multicycle op.
// Loaded when the op enters execute, decremented while the controller sits
// in MCYC; is_one tells the FSM that this is the last MCYC cycle.
module mcyc_counter
  import pipe_ctrl_pkg::*;
(
  input  logic                  clock,
  input  logic                  rst_l,
  input  logic                  load,
  input  logic [MCYC_LEN_W-1:0] load_val,
  input  logic                  dec,
  output logic                  is_one
);

  logic [MCYC_LEN_W-1:0] count;

  // Load takes precedence over decrement; the count never wraps below zero.
  always_ff @(posedge clock or negedge rst_l) begin
    if (!rst_l) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - {{(MCYC_LEN_W-1){1'b0}}, 1'b1};
    end
  end

  assign is_one = (count == {{(MCYC_LEN_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall/flush controller.
// RUN handles branches, multicycle ops, RAM read-after-write hazards and
// halt requests in that priority order; MCYC holds the pipe for the rest of
// a multicycle op; HALT holds it until a resume pulse.
// Optional feature macro: PIPE_CTRL_PERF_EN enables the saturating
// stall/flush performance counters; otherwise both counters read zero.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
(
  input logic       clock,
  input logic       rst_l,
  pipe_ctrl_if.slave bus
);

  pipe_state_t           state;
  pipe_state_t           next_state;
  ctrl_t                 ctrl;
  ctrl_t                 ctrl_out;
  logic                  hazard;
  logic                  ctr_load;
  logic                  ctr_dec;
  logic                  ctr_is_one;
  logic [MCYC_LEN_W-1:0] ctr_load_val;

  assign hazard       = bus.ram_wr_E & bus.ram_rd_D & (bus.K_E == bus.K_D);
  assign ctr_load_val = bus.mcyc_len - {{(MCYC_LEN_W-1){1'b0}}, 1'b1};

  mcyc_counter u_mcyc_counter (
    .clock    (clock),
    .rst_l    (rst_l),
    .load     (ctr_load),
    .load_val (ctr_load_val),
    .dec      (ctr_dec),
    .is_one   (ctr_is_one)
  );

  // State register; reset lands in RUN wherever the FSM was.
  always_ff @(posedge clock or negedge rst_l) begin
    if (!rst_l) begin
      state <= RUN;
    end else begin
      state <= next_state;
    end
  end

  // Next state and control outputs; RUN arbitrates, MCYC/HALT ignore requests.
  always_comb begin
    next_state = state;
    ctrl       = CTRL_IDLE;
    ctr_load   = 1'b0;
    ctr_dec    = 1'b0;
    case (state)
      RUN: begin
        if (bus.branch_taken_E) begin
          ctrl.flush    = 1'b1;
          ctrl.flush_DE = 1'b1;
        end else if (bus.mcyc_start_E) begin
          if (bus.mcyc_len >= 3'd2) begin
            ctrl.stall = 1'b1;
            ctr_load   = 1'b1;
            next_state = MCYC;
          end else if (bus.mcyc_len == 3'd1) begin
            ctrl.stall = 1'b1;
          end
        end else if (hazard) begin
          ctrl.stall = 1'b1;
        end else if (bus.halt_D) begin
          next_state = HALT;
        end
      end
      MCYC: begin
        ctrl.stall = 1'b1;
        ctrl.busy  = 1'b1;
        ctr_dec    = 1'b1;
        if (ctr_is_one) begin
          next_state = RUN;
        end
      end
      HALT: begin
        ctrl.stall  = 1'b1;
        ctrl.halted = 1'b1;
        if (bus.resume) begin
          next_state = RUN;
        end
      end
      default: begin
        next_state = RUN;
      end
    endcase
  end

  // Reset must silence the combinational outputs immediately, not at an edge.
  assign ctrl_out = rst_l ? ctrl : CTRL_IDLE;

  assign bus.stall    = ctrl_out.stall;
  assign bus.flush    = ctrl_out.flush;
  assign bus.flush_DE = ctrl_out.flush;
  assign bus.halted   = ctrl_out.halted;
  assign bus.busy     = ctrl_out.busy;

`ifdef PIPE_CTRL_PERF_EN
  logic [PERF_CNT_W-1:0] stall_cnt_q;
  logic [PERF_CNT_W-1:0] flush_cnt_q;

  // Saturating counts of stalled and flushed cycles.
  always_ff @(posedge clock or negedge rst_l) begin
    if (!rst_l) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (ctrl_out.stall) begin
        stall_cnt_q <= sat_inc(stall_cnt_q);
      end
      if (ctrl_out.flush) begin
        flush_cnt_q <= sat_inc(flush_cnt_q);
      end
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
`else
  assign bus.stall_cnt = '0;
  assign bus.flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl.
// Inputs change on the falling edge; outputs are sampled 1 time unit later,
// away from the rising edge where state updates.
module tb_pipe_ctrl;

  logic clock;
  logic rst_l;
  int   checks;
  int   failures;

  pipe_ctrl_if bus ();

  pipe_ctrl dut (
    .clock (clock),
    .rst_l (rst_l),
    .bus   (bus.slave)
  );

  // Free-running 10-unit clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Guard against a hung run.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [4:0] outs();
    return {bus.stall, bus.flush, bus.flush_DE, bus.halted, bus.busy};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One cycle: drive inputs on the falling edge, then check the flags
  // {stall, flush, flush_DE, halted, busy}.
  task automatic applyStimulus(input string tag, input logic br, input logic ms,
                               input logic [2:0] len, input logic wr, input logic rd,
                               input logic [11:0] ke, input logic [11:0] kd,
                               input logic halt, input logic res,
                               input logic [4:0] exp_flags);
    @(negedge clock);
    bus.branch_taken_E = br;
    bus.mcyc_start_E   = ms;
    bus.mcyc_len       = len;
    bus.ram_wr_E       = wr;
    bus.ram_rd_D       = rd;
    bus.K_E            = ke;
    bus.K_D            = kd;
    bus.halt_D         = halt;
    bus.resume         = res;
    #1;
    checkOutput(tag, {27'd0, outs()}, {27'd0, exp_flags});
  endtask

  task automatic idle(input string tag, input logic [4:0] exp_flags);
    applyStimulus(tag, 0, 0, 3'd0, 0, 0, 12'd0, 12'd0, 0, 0, exp_flags);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_l    = 1'b0;
    bus.branch_taken_E = 0; bus.mcyc_start_E = 0; bus.mcyc_len = 0;
    bus.ram_wr_E = 0; bus.ram_rd_D = 0; bus.K_E = 0; bus.K_D = 0;
    bus.halt_D = 0; bus.resume = 0;

    repeat (2) @(negedge clock);
    #1;
    checkOutput("reset_flags", {27'd0, outs()}, 32'd0);
    checkOutput("reset_stall_cnt", {16'd0, bus.stall_cnt}, 32'd0);
    checkOutput("reset_flush_cnt", {16'd0, bus.flush_cnt}, 32'd0);
    @(negedge clock);
    rst_l = 1'b1;

    idle("run_idle", 5'b00000);

    // Multicycle op of length 5: 5 stalls, busy on the last 4, then RUN.
    applyStimulus("mcyc5_c0", 0, 1, 3'd5, 0, 0, 12'd0, 12'd0, 0, 0, 5'b10000);
    for (int i = 1; i <= 4; i++) idle($sformatf("mcyc5_c%0d", i), 5'b10001);
    idle("mcyc5_done", 5'b00000);

    // Short multicycle ops.
    applyStimulus("mcyc1_c0", 0, 1, 3'd1, 0, 0, 12'd0, 12'd0, 0, 0, 5'b10000);
    idle("mcyc1_done", 5'b00000);
    applyStimulus("mcyc0", 0, 1, 3'd0, 0, 0, 12'd0, 12'd0, 0, 0, 5'b00000);
    idle("mcyc0_done", 5'b00000);

    // RAM read-after-write hazard on matching addresses only.
    applyStimulus("raw_match", 0, 0, 3'd0, 1, 1, 12'o2400, 12'o2400, 0, 0, 5'b10000);
    applyStimulus("raw_nomatch", 0, 0, 3'd0, 1, 1, 12'o2400, 12'o2401, 0, 0, 5'b00000);
    idle("raw_done", 5'b00000);

    // Branch beats hazard and halt in the same cycle.
    applyStimulus("branch_prio", 1, 0, 3'd0, 1, 1, 12'o2400, 12'o2400, 1, 0, 5'b01100);
    idle("branch_after", 5'b00000);

    // Halt held for 10 cycles, then resume with no flush.
    applyStimulus("halt_req", 0, 0, 3'd0, 0, 0, 12'd0, 12'd0, 1, 0, 5'b00000);
    for (int i = 0; i < 10; i++) begin
      applyStimulus($sformatf("halt_hold%0d", i), i == 3, i == 5, 3'd4, 0, 0,
                    12'd0, 12'd0, 0, 0, 5'b10010);
    end
    applyStimulus("resume_pulse", 0, 0, 3'd0, 0, 0, 12'd0, 12'd0, 0, 1, 5'b10010);
    idle("resumed", 5'b00000);

    // Reset in the second cycle of a length-7 op.
    applyStimulus("mcyc7_c0", 0, 1, 3'd7, 0, 0, 12'd0, 12'd0, 0, 0, 5'b10000);
    idle("mcyc7_c1", 5'b10001);
    rst_l = 1'b0;
    bus.branch_taken_E = 1'b1;
    #1;
    checkOutput("async_reset_flags", {27'd0, outs()}, 32'd0);
    checkOutput("async_reset_stall_cnt", {16'd0, bus.stall_cnt}, 32'd0);
    @(negedge clock);
    rst_l = 1'b1;
    idle("post_reset_run", 5'b00000);
    applyStimulus("mcyc2_c0", 0, 1, 3'd2, 0, 0, 12'd0, 12'd0, 0, 0, 5'b10000);
    idle("mcyc2_c1", 5'b10001);
    idle("mcyc2_done", 5'b00000);

`ifdef PIPE_CTRL_PERF_EN
    // Counters: one flush, then a long halt saturates the stall count.
    @(negedge clock);
    rst_l = 1'b0;
    #1;
    checkOutput("perf_reset", {bus.stall_cnt, bus.flush_cnt}, 32'd0);
    @(negedge clock);
    rst_l = 1'b1;
    applyStimulus("perf_branch", 1, 0, 3'd0, 0, 0, 12'd0, 12'd0, 0, 0, 5'b01100);
    applyStimulus("perf_halt", 0, 0, 3'd0, 0, 0, 12'd0, 12'd0, 1, 0, 5'b00000);
    checkOutput("perf_flush_cnt", {16'd0, bus.flush_cnt}, 32'd1);
    idle("perf_halt_c0", 5'b10010);
    repeat (70000) @(negedge clock);
    #1;
    checkOutput("perf_stall_sat", {16'd0, bus.stall_cnt}, 32'h0000FFFF);
    checkOutput("perf_flush_hold", {16'd0, bus.flush_cnt}, 32'd1);
`else
    checkOutput("stall_cnt_tied", {16'd0, bus.stall_cnt}, 32'd0);
    checkOutput("flush_cnt_tied", {16'd0, bus.flush_cnt}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
